// File: rtl/pckys_accum.sv
`default_nettype none
// ============================================================================
// Module      : pckys_accum
// Description : Registered ADD/SUB/ACC/CLR unit with valid/ready handshake,
//               optional saturation, running accumulator, sticky overflow
//               and accepted-operation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pckys_accum #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_ACC = 2'b10;
    localparam logic [1:0] c_OP_CLR = 2'b11;

    localparam logic [0:0] c_S_EMPTY = 1'b0;
    localparam logic [0:0] c_S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_res;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    // A held result frees the slot only when ena is high, so ena gates ready.
    assign in_ready = ena & (~out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (ena) begin
            if (w_accept) begin
                w_next_state = c_S_FULL;
            end else if ((r_state == c_S_FULL) && out_ready) begin
                w_next_state = c_S_EMPTY;
            end
        end
    end

    always_comb begin
        out_valid = (r_state == c_S_FULL);
    end

    always_comb begin
        w_sum   = '0;
        w_carry = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_sum   = {1'b0, a} + {1'b0, b};
                w_carry = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_sum   = {1'b0, a} - {1'b0, b};
                w_carry = (a < b);
            end
            c_OP_ACC: begin
                w_sum   = {1'b0, r_acc} + {1'b0, a};
                w_carry = w_sum[WIDTH];
            end
            default: begin
                w_sum   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    assign w_wrap = w_sum[WIDTH-1:0];

    generate
        if (SATURATE != 0) begin : g_sat
            // Borrow clamps to zero; carry clamps to all-ones.
            always_comb begin
                w_res = w_wrap;
                if (w_carry) begin
                    w_res = (op == c_OP_SUB) ? '0 : '1;
                end
            end
        end else begin : g_wrap
            assign w_res = w_wrap;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_count  <= r_count + 1'b1;
            if (op == c_OP_CLR) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_carry;
                if (op == c_OP_ACC) begin
                    r_acc <= w_res;
                end
            end
        end
    end

    assign result     = r_result;
    assign carry      = r_carry;
    assign acc        = r_acc;
    assign ovf_sticky = r_ovf;
    assign op_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pckys_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_pckys_accum
// Description : Scoreboard bench for pckys_accum in wrap and saturate modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pckys_accum;

    localparam int c_W     = 8;
    localparam int c_CW    = 4;
    localparam int c_MAX   = 256;
    localparam int c_CMAX  = 16;

    localparam logic [1:0] c_ADD = 2'b00;
    localparam logic [1:0] c_SUB = 2'b01;
    localparam logic [1:0] c_ACC = 2'b10;
    localparam logic [1:0] c_CLR = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [1:0]      op = 2'b00;
    logic [c_W-1:0]  a = '0;
    logic [c_W-1:0]  b = '0;

    logic            in_ready0, out_valid0, carry0, ovf0;
    logic [c_W-1:0]  result0, acc0;
    logic [c_CW-1:0] cnt0;
    logic            in_ready1, out_valid1, carry1, ovf1;
    logic [c_W-1:0]  result1, acc1;
    logic [c_CW-1:0] cnt1;

    pckys_accum #(.WIDTH(c_W), .SATURATE(0), .CNT_W(c_CW)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .carry(carry0), .acc(acc0),
        .ovf_sticky(ovf0), .op_count(cnt0)
    );

    pckys_accum #(.WIDTH(c_W), .SATURATE(1), .CNT_W(c_CW)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .carry(carry1), .acc(acc1),
        .ovf_sticky(ovf1), .op_count(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_W-1:0] r;
        logic           c;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 = wrapping unit, index 1 = saturating unit.
    int m_acc [2];
    int m_ovf [2];
    int m_cnt;
    bit m_full;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_op(input int s, input int o, input int x, input int y,
                                     output int r, output int c);
        int sum;
        r = 0;
        c = 0;
        case (o)
            0, 2: begin
                sum = (o == 0) ? (x + y) : (m_acc[s] + x);
                c   = (sum >= c_MAX) ? 1 : 0;
                r   = (c == 0) ? sum : ((s == 1) ? c_MAX - 1 : sum - c_MAX);
            end
            1: begin
                c = (x < y) ? 1 : 0;
                r = (c == 0) ? x - y : ((s == 1) ? 0 : x - y + c_MAX);
            end
            default: begin
                r = 0;
                c = 0;
            end
        endcase
        if (o == 3) begin
            m_acc[s] = 0;
            m_ovf[s] = 0;
        end else begin
            if (c != 0) m_ovf[s] = 1;
            if (o == 2) m_acc[s] = r;
        end
    endfunction

    // Reference model: checks state against the DUTs, then applies this edge.
    always @(negedge clk) begin
        bit exp_rdy;
        int r, c;
        ent_t e;
        if (!rst_n) begin
            m_acc[0] = 0; m_acc[1] = 0;
            m_ovf[0] = 0; m_ovf[1] = 0;
            m_cnt    = 0;
            m_full   = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            exp_rdy = ena && (!m_full || out_ready);
            check("in_ready_wrap", int'(in_ready0), int'(exp_rdy));
            check("in_ready_sat", int'(in_ready1), int'(exp_rdy));
            check("out_valid_wrap", int'(out_valid0), int'(m_full));
            check("out_valid_sat", int'(out_valid1), int'(m_full));
            check("acc_wrap", int'(acc0), m_acc[0]);
            check("acc_sat", int'(acc1), m_acc[1]);
            check("ovf_wrap", int'(ovf0), m_ovf[0]);
            check("ovf_sat", int'(ovf1), m_ovf[1]);
            check("op_count_wrap", int'(cnt0), m_cnt);
            check("op_count_sat", int'(cnt1), m_cnt);
            if (ena) begin
                if (in_valid && exp_rdy) begin
                    model_op(0, int'(op), int'(a), int'(b), r, c);
                    e.r = c_W'(r); e.c = c[0];
                    q0.push_back(e);
                    model_op(1, int'(op), int'(a), int'(b), r, c);
                    e.r = c_W'(r); e.c = c[0];
                    q1.push_back(e);
                    m_cnt  = (m_cnt + 1) % c_CMAX;
                    m_full = 1'b1;
                end else if (m_full && out_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Monitor: compares the presented result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid0) begin
                if (q0.size() == 0) check("q0_nonempty", 0, 1);
                else begin
                    check("result_wrap", int'(result0), int'(q0[0].r));
                    check("carry_wrap", int'(carry0), int'(q0[0].c));
                    if (ena && out_ready) void'(q0.pop_front());
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) check("q1_nonempty", 0, 1);
                else begin
                    check("result_sat", int'(result1), int'(q1[0].r));
                    check("carry_sat", int'(carry1), int'(q1[0].c));
                    if (ena && out_ready) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [1:0] o, input int x, input int y,
                       input bit rdy, input bit en);
        @(posedge clk);
        #1;
        in_valid  = v;
        op        = o;
        a         = c_W'(x);
        b         = c_W'(y);
        out_ready = rdy;
        ena       = en;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid0) + int'(out_valid1), 0);
        check("rst_result", int'(result0) + int'(result1), 0);
        check("rst_carry", int'(carry0) + int'(carry1), 0);
        check("rst_acc", int'(acc0) + int'(acc1), 0);
        check("rst_ovf", int'(ovf0) + int'(ovf1), 0);
        check("rst_op_count", int'(cnt0) + int'(cnt1), 0);
        check("rst_in_ready", int'(in_ready0), int'(ena));
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int x, y;
        logic [1:0] o;
        do_reset();

        // Wrap vs saturate ADD/SUB
        cyc(1, c_ADD, 200, 100, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("add_wrap_res", int'(result0), 44);
        check("add_wrap_carry", int'(carry0), 1);
        check("add_wrap_ovf", int'(ovf0), 1);
        check("add_sat_res", int'(result1), 255);
        cyc(1, c_SUB, 5, 7, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("sub_wrap_res", int'(result0), 254);
        check("sub_wrap_carry", int'(carry0), 1);
        check("sub_sat_res", int'(result1), 0);
        check("sub_sat_carry", int'(carry1), 1);
        check("count_after_two", int'(cnt0), 2);

        // Saturating accumulate from 250
        cyc(1, c_CLR, 0, 0, 1, 1);
        cyc(1, c_ACC, 250, 0, 1, 1);
        cyc(1, c_ACC, 10, 0, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("acc_sat_clamp", int'(acc1), 255);
        check("acc_wrap_260", int'(acc0), 4);

        // Back-to-back accumulate then clear
        cyc(1, c_CLR, 0, 0, 1, 1);
        cyc(1, c_ACC, 3, 0, 1, 1);
        cyc(1, c_ACC, 4, 0, 1, 1);
        @(negedge clk);
        check("acc_step1", int'(result0), 3);
        cyc(1, c_ACC, 5, 0, 1, 1);
        @(negedge clk);
        check("acc_step2", int'(result0), 7);
        cyc(1, c_CLR, 0, 0, 1, 1);
        @(negedge clk);
        check("acc_step3", int'(result0), 12);
        check("acc_total", int'(acc0), 12);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("clr_result", int'(result0), 0);
        check("clr_acc", int'(acc0), 0);
        check("clr_ovf", int'(ovf0), 0);
        check("clr_count", int'(cnt0), 10);

        // Backpressure: result holds, then consume+accept on one edge
        cyc(1, c_ADD, 10, 20, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, c_ADD, 1, 1, 0, 1);
            @(negedge clk);
            check("bp_in_ready", int'(in_ready0), 0);
            check("bp_hold", int'(result0), 30);
        end
        cyc(1, c_ADD, 1, 1, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("bp_new_result", int'(result0), 2);

        // Enable freeze
        cyc(1, c_ADD, 7, 8, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, c_ADD, 9, 9, 1, 0);
            @(negedge clk);
            check("frz_in_ready", int'(in_ready0), 0);
            check("frz_out_valid", int'(out_valid0), 1);
            check("frz_result", int'(result0), 15);
        end
        cyc(1, c_ADD, 9, 9, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("frz_resume", int'(result0), 18);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            o = 2'($urandom_range(0, 3));
            if (o == c_CLR && ($urandom_range(0, 3) != 0)) o = c_ACC;
            x = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) != 0, o, x, y,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) != 0);
        end

        // Reset with a pending result discards it
        cyc(1, c_ADD, 1, 2, 0, 1);
        cyc(0, c_ADD, 0, 0, 0, 1);
        do_reset();
        cyc(1, c_ADD, 3, 4, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("post_rst_result", int'(result0), 7);
        check("post_rst_count", int'(cnt0), 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        cyc(0, c_ADD, 0, 0, 1, 1);
        @(negedge clk);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pckys_accum.md
# pckys_accum

Parametrised registered arithmetic/accumulator unit for the pckys game datapath: the sequential successor to the top-level combinational pin adder. Accepts operand pairs over a valid/ready handshake and executes ADD, SUB, ACCumulate or CLeaR. Produces a registered result with carry/borrow, an optional saturation mode, a running accumulator, a sticky overflow flag and an accepted-operation counter. Instantiated under the tt_um top, with operands driven from ui_in/uio_in and results to uo_out.

## Interface
- WIDTH, 8: operand, result and accumulator width (≥2).
- SATURATE, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp to all-ones on carry or to 0 on borrow.
- CNT_W, 8: width of the accepted-operation counter.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept this cycle.
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned; ignored for ACC and CLR).
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- carry  out  1  carry (ADD/ACC) or borrow (SUB) of the result in the register.
- acc  out  WIDTH  accumulator register.
- ovf_sticky  out  1  set by any carry/borrow; cleared only by CLR or reset.
- op_count  out  CNT_W  accepted operations, wraps modulo 2^CNT_W.

## Operation
- Accept = in_valid & in_ready. in_ready = ena & (!out_valid | out_ready), which gives full throughput under continuous out_ready.
- On accept, compute in WIDTH+1 bits, unsigned:
  - ADD: s = a + b; carry = s[WIDTH].
  - SUB: s = a - b; carry = borrow = (a < b).
  - ACC: s = acc + a; carry = s[WIDTH]; acc <= result.
  - CLR: result = 0; carry = 0; acc <= 0; ovf_sticky <= 0.
- result = s[WIDTH-1:0] when SATURATE=0. When SATURATE=1:
  - carry on ADD/ACC gives all-ones.
  - borrow on SUB gives 0.
  - carry is reported in both modes.
- ACC stores the post-saturation value.
- ovf_sticky <= ovf_sticky | carry for ADD/SUB/ACC. CLR overrides.
- op_count increments on every accept, CLR included. The CLR accept itself does not reset it.
- acc changes only on ACC or CLR accepts.
- Two-state output control:
  - EMPTY: out_valid=0. Accept moves to FULL.
  - FULL: out_valid=1. out_ready without accept moves to EMPTY. out_ready with accept stays FULL with the new result. No out_ready holds result/carry stable.
- ena low: in_ready=0 and no state changes. out_valid, result and the other outputs hold. An out_ready asserted while ena is low is ignored; the result is not consumed.

## Timing
- Reset (async assert, sync use after deassert): result=0, carry=0, acc=0, ovf_sticky=0, op_count=0, out_valid=0. in_ready=ena immediately after reset.
- Latency: an accept at edge N gives result/carry/out_valid visible after edge N. acc/ovf_sticky/op_count update on the same edge.
- ACC back-to-back: the second ACC uses the acc value updated by the first (no hazard).
- Reset mid-operation clears a pending result. A result held under backpressure is lost, not replayed.
- Wrap: op_count at 2^CNT_W-1 plus one accept gives 0. ADD 0xFF+0x01 (WIDTH=8, wrap) gives result 0x00, carry 1.
- Simultaneous out_ready and accept in FULL: the old result is consumed and the new one is loaded on the same edge. No bubble, no duplicate.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → all outputs 0 asynchronously; in_ready=1 once ena=1.
- Wrap ADD/SUB (WIDTH=8, SATURATE=0): ADD 200+100 → result 44, carry 1, ovf_sticky 1. SUB 5-7 → result 254, carry 1. op_count=2.
- Saturation (SATURATE=1): ADD 200+100 → 255, carry 1. SUB 5-7 → 0, carry 1. ACC from 250 with a=10 → acc 255.
- Accumulate/clear: ACC a=3, 4, 5 back-to-back with out_ready=1 → results 3, 7, 12; acc=12; one result per cycle. Then CLR → result 0, acc 0, ovf_sticky 0, op_count 4.
- Backpressure: out_ready=0 after one ADD → in_ready=0; result holds for 5 cycles despite new in_valid. Raise out_ready with a pending op → consume and accept on the same edge.
- Enable freeze: ena=0 for 3 cycles with in_valid=1 and out_ready=1 → no accept, out_valid/result/acc/op_count unchanged. Resume on ena=1.
